// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-stage controller:
// request opcodes, fault codes and access sizes.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_SPSET = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_MISALIGN = 2'b01,
    F_RANGE    = 2'b10,
    F_STACK    = 2'b11
  } fault_e;

  localparam int SIZE_BYTE = 1;
  localparam int SIZE_WORD = 4;

endpackage

// File: rtl/mem_addr_check.sv
// Effective-address generation and fault
// classification for one memory-stage request.
module mem_addr_check
  import mem_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 1024,
  parameter int SP_RESET  = 1024
) (
  input  logic [2:0]      op_i,
  input  logic            byte_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] index_i,
  input  logic            indexed_i,
  input  logic [XLEN-1:0] sp_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] ea_o,
  output logic            fault_hit_o,
  output logic [1:0]      fault_code_o
);

  logic [XLEN-1:0] size;
  logic [XLEN:0]   ea_end;
  logic [XLEN:0]   pop_end;
  logic            is_load;
  logic            is_store;
  logic            is_push;
  logic            is_pop;
  logic            is_spset;
  logic            is_mem;
  fault_e          code;

  assign size     = byte_i ? XLEN'(SIZE_BYTE)
                           : XLEN'(SIZE_WORD);
  assign is_load  = op_i == OP_LOAD;
  assign is_store = op_i == OP_STORE;
  assign is_push  = op_i == OP_PUSH;
  assign is_pop   = op_i == OP_POP;
  assign is_spset = op_i == OP_SPSET;
  assign is_mem   = is_load | is_store
                  | is_push | is_pop;

  // Stack ops address relative to sp; others use base(+index)
  always_comb begin
    ea_o = indexed_i ? base_i + index_i : base_i;
    unique case (1'b1)
      is_push: ea_o = sp_i - size;
      is_pop:  ea_o = sp_i;
      default: ;
    endcase
  end

  // End addresses carry one extra bit so wraparound is caught
  assign ea_end  = {1'b0, ea_o} + {1'b0, size};
  assign pop_end = {1'b0, sp_i} + {1'b0, size};

  // Prioritised fault classification
  always_comb begin
    code = F_NONE;
    if (is_mem) begin
      if (!byte_i && ea_o[1:0] != 2'b00) begin
        code = F_MISALIGN;
      end else if ((is_push && sp_i < size) ||
                   (is_pop && pop_end >
                    (XLEN+1)'(SP_RESET))) begin
        code = F_STACK;
      end else if (!is_push && ea_end >
                   (XLEN+1)'(MEM_BYTES)) begin
        code = F_RANGE;
      end
    end else if (is_spset) begin
      if (wdata_i[1:0] != 2'b00) begin
        code = F_MISALIGN;
      end else if (wdata_i > XLEN'(SP_RESET)) begin
        code = F_STACK;
      end
    end
  end

  assign fault_hit_o  = code != F_NONE;
  assign fault_code_o = code;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: owns sp, drives the data
// memory and holds one registered writeback slot.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int SP_RESET  = 1024,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_byte,
  input  logic            req_indexed,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_index,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_rd,
  input  logic            fault_clr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_byte,
  input  logic [XLEN-1:0] mem_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [3:0]      wb_rd,
  output logic [XLEN-1:0] sp,
  output logic            fault,
  output logic [1:0]      fault_code
);

  logic [XLEN-1:0] sp_q, sp_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [3:0]      wb_rd_q, wb_rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] size;
  logic            chk_hit;
  logic [1:0]      chk_code;
  logic            accept;
  logic            ok;
  logic            is_load;
  logic            is_store;
  logic            is_push;
  logic            is_pop;
  logic            is_spset;

  mem_addr_check #(
    .XLEN      (XLEN),
    .MEM_BYTES (MEM_BYTES),
    .SP_RESET  (SP_RESET)
  ) u_check (
    .op_i         (req_op),
    .byte_i       (req_byte),
    .base_i       (req_base),
    .index_i      (req_index),
    .indexed_i    (req_indexed),
    .sp_i         (sp_q),
    .wdata_i      (req_wdata),
    .ea_o         (ea),
    .fault_hit_o  (chk_hit),
    .fault_code_o (chk_code)
  );

  assign size     = req_byte ? XLEN'(SIZE_BYTE)
                             : XLEN'(SIZE_WORD);
  assign is_load  = req_op == OP_LOAD;
  assign is_store = req_op == OP_STORE;
  assign is_push  = req_op == OP_PUSH;
  assign is_pop   = req_op == OP_POP;
  assign is_spset = req_op == OP_SPSET;

  // A full, unconsumed slot stalls every op to keep order
  assign req_ready = !fault_q
                   & (!wb_valid_q | wb_ready);
  assign accept    = req_valid & req_ready & !rst;
  assign ok        = accept & !chk_hit;

  assign mem_addr = ea;
  assign mem_wd   = req_wdata;
  assign mem_byte = req_byte;
  assign mem_we   = ok & (is_store | is_push);

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign sp         = sp_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

  // Next state for sp, sticky fault and writeback slot
  always_comb begin
    sp_d         = sp_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_valid_d   = wb_valid_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    if (fault_q && fault_clr) begin
      fault_d      = 1'b0;
      fault_code_d = 2'b00;
    end
    if (accept && chk_hit) begin
      fault_d      = 1'b1;
      fault_code_d = chk_code;
    end
    if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end
    if (ok) begin
      unique case (1'b1)
        is_push:  sp_d = ea;
        is_pop:   sp_d = sp_q + size;
        is_spset: sp_d = req_wdata;
        default:  ;
      endcase
      if (is_load || is_pop) begin
        wb_valid_d = 1'b1;
        wb_data_d  = mem_rd;
        wb_rd_d    = req_rd;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q         <= XLEN'(SP_RESET);
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      sp_q         <= sp_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_valid_q   <= wb_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed
// sequences then randomized traffic vs a byte model.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int SPR  = 1024;
  localparam int MEMB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_byte = 1'b0;
  logic        req_indexed = 1'b0;
  logic [31:0] req_base = '0;
  logic [31:0] req_index = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_rd = '0;
  logic        fault_clr = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_byte;
  logic [31:0] mem_rd;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic [31:0] sp;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .MEM_BYTES (MEMB),
    .SP_RESET  (SPR),
    .XLEN      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_byte    (req_byte),
    .req_indexed (req_indexed),
    .req_base    (req_base),
    .req_index   (req_index),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .fault_clr   (fault_clr),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_byte    (mem_byte),
    .mem_rd      (mem_rd),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .sp          (sp),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // Data memory seen by the DUT
  logic [7:0] dmem [0:1023];
  // Reference memory owned by the model
  logic [7:0] refmem [0:1023];

  initial begin
    for (int k = 0; k < 1024; k++) begin
      dmem[k]   = 8'h00;
      refmem[k] = 8'h00;
    end
  end

  logic [9:0] ma;
  assign ma = mem_addr[9:0];

  always_comb begin
    mem_rd = '0;
    if (mem_byte) mem_rd = {24'h0, dmem[ma]};
    else mem_rd = {dmem[ma + 10'd3], dmem[ma + 10'd2],
                   dmem[ma + 10'd1], dmem[ma]};
  end

  always @(posedge clk) begin
    if (mem_we) begin
      dmem[ma] <= mem_wd[7:0];
      if (!mem_byte) begin
        dmem[ma + 10'd1] <= mem_wd[15:8];
        dmem[ma + 10'd2] <= mem_wd[23:16];
        dmem[ma + 10'd3] <= mem_wd[31:24];
      end
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rd;
  } wb_t;

  wb_t expq[$];
  int  checks = 0;
  int  fails  = 0;

  logic [31:0] m_sp = 32'(SPR);
  logic        m_fault = 1'b0;
  logic [1:0]  m_code = 2'b00;
  logic        m_wbv = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(
      input logic [31:0] a, input logic by);
    logic [9:0] x;
    x = a[9:0];
    if (by) return {24'h0, refmem[x]};
    return {refmem[x + 10'd3], refmem[x + 10'd2],
            refmem[x + 10'd1], refmem[x]};
  endfunction

  task automatic ref_wr(input logic [31:0] a,
                        input logic by,
                        input logic [31:0] d);
    logic [9:0] x;
    x = a[9:0];
    refmem[x] = d[7:0];
    if (!by) begin
      refmem[x + 10'd1] = d[15:8];
      refmem[x + 10'd2] = d[23:16];
      refmem[x + 10'd3] = d[31:24];
    end
  endtask

  // One clock of stimulus plus model update
  task automatic drive(input logic v,
                       input logic [2:0] op,
                       input logic by,
                       input logic ix,
                       input logic [31:0] b,
                       input logic [31:0] i,
                       input logic [31:0] wd,
                       input logic [3:0] rd,
                       input logic wbr,
                       input logic fc,
                       input logic r);
    logic        exp_ready, acc, we_exp, loaded;
    logic [31:0] ea, size;
    logic [1:0]  code;
    @(negedge clk);
    chk("sp", sp, m_sp);
    chk("fault", {31'h0, fault}, {31'h0, m_fault});
    chk("fault_code", {30'h0, fault_code},
        {30'h0, m_code});
    chk("wb_valid", {31'h0, wb_valid}, {31'h0, m_wbv});
    req_valid   = v;
    req_op      = op;
    req_byte    = by;
    req_indexed = ix;
    req_base    = b;
    req_index   = i;
    req_wdata   = wd;
    req_rd      = rd;
    wb_ready    = wbr;
    fault_clr   = fc;
    rst         = r;
    #1;
    exp_ready = !m_fault && (!m_wbv || wbr);
    chk("req_ready", {31'h0, req_ready},
        {31'h0, exp_ready});
    if (r) begin
      chk("mem_we_in_reset", {31'h0, mem_we}, 32'h0);
      m_sp = 32'(SPR);
      m_fault = 1'b0;
      m_code = 2'b00;
      m_wbv = 1'b0;
      expq.delete();
    end else begin
      acc = v && exp_ready;
      we_exp = 1'b0;
      loaded = 1'b0;
      ea = '0;
      if (m_fault && fc) begin
        m_fault = 1'b0;
        m_code = 2'b00;
      end
      if (acc) begin
        size = by ? 32'd1 : 32'd4;
        case (op)
          OP_LOAD, OP_STORE: ea = ix ? b + i : b;
          OP_PUSH: ea = m_sp - size;
          OP_POP:  ea = m_sp;
          default: ea = '0;
        endcase
        code = 2'b00;
        if (op <= 3'd3) begin
          if (!by && (ea % 4) != 0) code = 2'b01;
          else if ((op == OP_PUSH && m_sp < size) ||
                   (op == OP_POP &&
                    64'(m_sp) + 64'(size) > 64'(SPR)))
            code = 2'b11;
          else if (op != OP_PUSH &&
                   64'(ea) + 64'(size) > 64'(MEMB))
            code = 2'b10;
        end else if (op == OP_SPSET) begin
          if (wd[1:0] != 2'b00) code = 2'b01;
          else if (wd > 32'(SPR)) code = 2'b11;
        end
        if (code != 2'b00) begin
          m_fault = 1'b1;
          m_code = code;
        end else begin
          case (op)
            OP_STORE: begin
              ref_wr(ea, by, wd);
              we_exp = 1'b1;
            end
            OP_PUSH: begin
              ref_wr(ea, by, wd);
              we_exp = 1'b1;
              m_sp = ea;
            end
            OP_POP: begin
              expq.push_back('{data: ref_rd(ea, by),
                               rd: rd});
              loaded = 1'b1;
              m_sp = m_sp + size;
            end
            OP_LOAD: begin
              expq.push_back('{data: ref_rd(ea, by),
                               rd: rd});
              loaded = 1'b1;
            end
            OP_SPSET: m_sp = wd;
            default: ;
          endcase
        end
      end
      chk("mem_we", {31'h0, mem_we}, {31'h0, we_exp});
      if (we_exp) chk("mem_addr", mem_addr, ea);
      m_wbv = loaded ? 1'b1 : (wbr ? 1'b0 : m_wbv);
    end
  endtask

  task automatic idle(input logic wbr, input logic fc);
    drive(0, OP_LOAD, 0, 0, 0, 0, 0, 0, wbr, fc, 0);
  endtask

  task automatic rand_cycle();
    logic        v, by, ix, wbr, fc, r;
    logic [2:0]  op;
    logic [31:0] b, i, wd;
    logic [3:0]  rd;
    v  = $urandom_range(0, 4) != 0;
    op = 3'($urandom_range(0, 7));
    by = 1'($urandom_range(0, 1));
    ix = $urandom_range(0, 2) == 0;
    if ($urandom_range(0, 19) == 0) b = $urandom;
    else if ($urandom_range(0, 3) == 0)
      b = $urandom_range(0, 1100);
    else b = 4 * $urandom_range(0, 255);
    i = ($urandom_range(0, 9) == 0) ? $urandom
                                    : 4 * $urandom_range(0, 8);
    if (op == OP_SPSET) begin
      if ($urandom_range(0, 5) == 0)
        wd = $urandom_range(0, 1100);
      else wd = 4 * $urandom_range(0, 256);
    end else begin
      wd = $urandom;
    end
    rd  = 4'($urandom_range(0, 15));
    wbr = $urandom_range(0, 3) != 0;
    fc  = $urandom_range(0, 2) == 0;
    r   = $urandom_range(0, 99) == 0;
    if (r) wbr = 1'b0;
    drive(v, op, by, ix, b, i, wd, rd, wbr, fc, r);
  endtask

  // Monitor: checks each result as the consumer takes it
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL wb_unexpected actual=%h required=none",
                   wb_data);
        end else begin
          e = expq.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", {28'h0, wb_rd}, {28'h0, e.rd});
        end
      end
    end
  end

  initial begin
    drive(0, OP_LOAD, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    drive(1, OP_STORE, 0, 0, 32'h10, 0,
          32'hDEADBEEF, 0, 1, 0, 0);
    chk("st_we", {31'h0, mem_we}, 32'h1);
    chk("st_addr", mem_addr, 32'h10);
    drive(1, OP_LOAD, 0, 0, 32'h10, 0, 0, 3, 1, 0, 0);
    idle(1, 0);
    chk("ld_valid", {31'h0, wb_valid}, 32'h1);
    chk("ld_data", wb_data, 32'hDEADBEEF);
    chk("ld_rd", {28'h0, wb_rd}, 32'd3);

    drive(1, OP_PUSH, 0, 0, 0, 0, 32'h11, 0, 1, 0, 0);
    chk("sp0", sp, 32'd1024);
    drive(1, OP_PUSH, 1, 0, 0, 0, 32'h22, 0, 1, 0, 0);
    chk("sp1", sp, 32'd1020);
    drive(1, OP_POP, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("sp2", sp, 32'd1019);
    drive(1, OP_POP, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    chk("sp3", sp, 32'd1020);
    chk("pop_b", wb_data, 32'h22);
    idle(1, 0);
    chk("sp4", sp, 32'd1024);
    chk("pop_w", wb_data, 32'h11);

    drive(1, OP_POP, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(1, 0);
    chk("uflow_fault", {31'h0, fault}, 32'h1);
    chk("uflow_code", {30'h0, fault_code}, 32'h3);
    chk("uflow_ready", {31'h0, req_ready}, 32'h0);
    chk("uflow_sp", sp, 32'd1024);
    drive(1, OP_LOAD, 1, 0, 32'd1023, 0, 0, 4, 1, 1, 0);
    drive(1, OP_LOAD, 1, 0, 32'd1023, 0, 0, 4, 1, 0, 0);
    chk("clr_fault", {31'h0, fault}, 32'h0);
    chk("clr_ready", {31'h0, req_ready}, 32'h1);

    drive(1, OP_LOAD, 0, 1, 32'h100, 32'h2, 0, 0, 1, 0, 0);
    idle(1, 1);
    chk("idx_code", {30'h0, fault_code}, 32'h1);
    drive(1, OP_LOAD, 0, 0, 32'd1024, 0, 0, 0, 1, 0, 0);
    idle(1, 1);
    chk("range_code", {30'h0, fault_code}, 32'h2);
    drive(1, OP_LOAD, 1, 0, 32'd1023, 0, 0, 7, 1, 0, 0);
    idle(1, 0);
    chk("lb_nofault", {31'h0, fault}, 32'h0);

    drive(1, OP_LOAD, 0, 0, 32'h10, 0, 0, 5, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, OP_LOAD, 1, 0, 32'h10, 0, 0, 6, 0, 0, 0);
      chk("stall_ready", {31'h0, req_ready}, 32'h0);
      chk("stall_data", wb_data, 32'hDEADBEEF);
    end
    drive(1, OP_LOAD, 1, 0, 32'h10, 0, 0, 6, 1, 0, 0);
    idle(1, 0);
    chk("refill_valid", {31'h0, wb_valid}, 32'h1);
    chk("refill_data", wb_data, 32'hEF);

    drive(1, OP_PUSH, 0, 0, 0, 0, 32'h55, 0, 1, 0, 0);
    drive(1, OP_PUSH, 0, 0, 0, 0, 32'h66, 0, 0, 0, 1);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    idle(1, 0);
    chk("rst_sp", sp, 32'd1024);
    chk("rst_wbv", {31'h0, wb_valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);

    for (int n = 0; n < 3000; n++) rand_cycle();

    idle(1, 1);
    idle(1, 0);
    idle(1, 0);
    chk("queue_empty", expq.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
